rice_core_if_stage: RTL and testbench



---
 rtl/rice_core_pkg.sv | 29 ++
 rtl/rice_core_fetch_buffer.sv | 81 ++++++++
 rtl/rice_core_if_stage.sv | 139 +++++++++++++
 tb/tb_rice_core_if_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rice_core_pkg.sv
`default_nettype none
// ============================================================================
// rice_core_pkg : shared types for the rice core front end
// Revision      : 1.0
// ============================================================================
package rice_core_pkg;

  localparam int unsigned RICE_XLEN = 32;
  localparam int unsigned RICE_ILEN = 32;

  typedef struct packed {
    logic                 valid;
    logic [RICE_XLEN-1:0] pc;
    logic [RICE_ILEN-1:0] inst;
  } rice_core_if_result;

  typedef struct packed {
    logic                 filled;
    logic [RICE_XLEN-1:0] pc;
    logic [RICE_ILEN-1:0] inst;
  } rice_core_fetch_slot;

  // One extra bit above the index so full and empty are distinguishable.
  function automatic int unsigned rice_ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rice_core_fetch_buffer.sv
`default_nettype none
// ============================================================================
// rice_core_fetch_buffer : in-order fetch slot FIFO (alloc / fill / pop)
// Revision               : 1.0
// ============================================================================
module rice_core_fetch_buffer
  import rice_core_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = rice_ptr_width(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_alloc,
  input  logic [RICE_XLEN-1:0] i_alloc_pc,
  input  logic                 i_fill,
  input  logic [RICE_ILEN-1:0] i_fill_inst,
  input  logic                 i_pop,
  output rice_core_fetch_slot  o_head,
  output logic [PW-1:0]        o_free,
  output logic [PW-1:0]        o_unfilled
);

  localparam int unsigned IW = PW - 1;

  rice_core_fetch_slot slot_q [DEPTH];
  rice_core_fetch_slot slot_d [DEPTH];
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q,  fill_d;
  logic [PW-1:0] read_q,  read_d;

  always_comb begin
    slot_d  = slot_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    read_d  = read_q;
    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i].filled = 1'b0;
      alloc_d = '0;
      fill_d  = '0;
      read_d  = '0;
    end else begin
      // Pop first: a full buffer may re-allocate the slot being popped.
      if (i_pop) begin
        slot_d[read_q[IW-1:0]].filled = 1'b0;
        read_d = read_q + 1'b1;
      end
      if (i_alloc) begin
        slot_d[alloc_q[IW-1:0]].pc     = i_alloc_pc;
        slot_d[alloc_q[IW-1:0]].filled = 1'b0;
        alloc_d = alloc_q + 1'b1;
      end
      if (i_fill) begin
        slot_d[fill_q[IW-1:0]].inst   = i_fill_inst;
        slot_d[fill_q[IW-1:0]].filled = 1'b1;
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
      read_q  <= '0;
    end else begin
      slot_q  <= slot_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      read_q  <= read_d;
    end
  end

  assign o_head     = slot_q[read_q[IW-1:0]];
  assign o_free     = PW'(DEPTH) - (alloc_q - read_q);
  assign o_unfilled = alloc_q - fill_q;

endmodule
`default_nettype wire

// File: rtl/rice_core_if_stage.sv
`default_nettype none
// ============================================================================
// rice_core_if_stage : instruction fetch, request issue and flush discard
// Revision           : 1.0
// ============================================================================
module rice_core_if_stage
  import rice_core_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     DEPTH        = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic            o_request_valid,
  input  logic            i_request_ready,
  output logic [XLEN-1:0] o_request_address,
  input  logic            i_response_valid,
  input  logic [31:0]     i_response_data,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_inst
);

  localparam int unsigned PW = rice_ptr_width(DEPTH);
  // Headroom for several flushes landing before the bus has drained.
  localparam int unsigned DW = PW + 3;

  logic            armed_q,    armed_d;
  logic            pending_q,  pending_d;
  logic            stale_q,    stale_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [DW-1:0]   discard_q,  discard_d;

  rice_core_fetch_slot head;
  rice_core_if_result  if_result;
  logic [PW-1:0]   free_cnt;
  logic [PW-1:0]   unfilled;
  logic [PW:0]     free_eff;
  logic            issue, req_valid, accept, resp_known, resp_ok;
  logic            do_alloc, do_fill, do_pop;
  logic [XLEN-1:0] req_addr;
  logic            unused_flush_lsbs;

  assign unused_flush_lsbs = ^i_flush_pc[1:0];

  always_comb begin
    if_result.valid = head.filled;
    if_result.pc    = head.pc;
    if_result.inst  = head.inst;
  end

  // A slot popped this cycle can be re-allocated by a request accepted this cycle.
  assign do_pop     = if_result.valid && !i_stall;
  assign free_eff   = {1'b0, free_cnt} + {{PW{1'b0}}, do_pop};
  assign issue      = armed_q && !pending_q && i_enable && !i_flush && (free_eff != '0);
  assign req_valid  = pending_q || issue;
  assign req_addr   = pending_q ? req_addr_q : fetch_pc_q;
  assign accept     = req_valid && i_request_ready;
  assign resp_known = (discard_q != '0) || (unfilled != '0);
  assign resp_ok    = i_response_valid && resp_known;
  assign do_alloc   = accept && !stale_q && !i_flush;
  assign do_fill    = resp_ok && (discard_q == '0) && !i_flush;

  always_comb begin
    armed_d    = 1'b1;
    pending_d  = req_valid && !i_request_ready;
    req_addr_d = req_addr;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    stale_d    = stale_q;
    if (i_flush) begin
      fetch_pc_d = {i_flush_pc[XLEN-1:2], 2'b00};
      discard_d  = discard_q + DW'(unfilled) + DW'(accept) - DW'(resp_ok);
      stale_d    = pending_q && !i_request_ready;
    end else begin
      if (accept && !stale_q) fetch_pc_d = fetch_pc_q + XLEN'(4);
      discard_d = discard_q + DW'(accept && stale_q)
                            - DW'(resp_ok && (discard_q != '0));
      stale_d   = stale_q && !accept;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      armed_q    <= 1'b0;
      pending_q  <= 1'b0;
      stale_q    <= 1'b0;
      req_addr_q <= RESET_VECTOR;
      fetch_pc_q <= RESET_VECTOR;
      discard_q  <= '0;
    end else begin
      armed_q    <= armed_d;
      pending_q  <= pending_d;
      stale_q    <= stale_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  rice_core_fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_fetch_buffer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_flush),
    .i_alloc     (do_alloc),
    .i_alloc_pc  (req_addr),
    .i_fill      (do_fill),
    .i_fill_inst (i_response_data),
    .i_pop       (do_pop),
    .o_head      (head),
    .o_free      (free_cnt),
    .o_unfilled  (unfilled)
  );

  assign o_request_valid   = req_valid;
  assign o_request_address = req_addr;
  assign o_if_valid        = if_result.valid;
  assign o_if_pc           = if_result.pc;
  assign o_if_inst         = if_result.inst;

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst_n && i_response_valid) begin
      assert (resp_known)
        else $warning("rice_core_if_stage: response with no outstanding request ignored");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rice_core_if_stage.sv
`default_nettype none
// ============================================================================
// tb_rice_core_if_stage : scoreboard bench with an in-order 1-cycle bus model
// Revision              : 1.0
// ============================================================================
module tb_rice_core_if_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, enable, stall, flush, req_ready, resp_valid;
  logic [31:0] flush_pc, resp_data;
  logic        req_valid, if_valid;
  logic [31:0] req_addr, if_pc, if_inst;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cnt = 0;
  int first_acc = -1;
  logic resp_on = 1'b1;
  logic spur    = 1'b0;
  exp_t        expq[$];
  logic [31:0] rq[$];
  logic [31:0] acc_addrs[$];
  int          pop_cyc[$];

  rice_core_if_stage #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .DEPTH        (2)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_enable          (enable),
    .i_stall           (stall),
    .i_flush           (flush),
    .i_flush_pc        (flush_pc),
    .o_request_valid   (req_valid),
    .i_request_ready   (req_ready),
    .o_request_address (req_addr),
    .i_response_valid  (resp_valid),
    .i_response_data   (resp_data),
    .o_if_valid        (if_valid),
    .o_if_pc           (if_pc),
    .o_if_inst         (if_inst)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a << 8) | 32'h0000_0013;
  endfunction

  // Bus model: records accepts at mid-cycle, answers one cycle later in order.
  initial begin
    logic        nv;
    logic [31:0] nd;
    forever begin
      @(negedge clk);
      if (rst_n && req_valid && req_ready) begin
        rq.push_back(req_addr);
        acc_addrs.push_back(req_addr);
        if (acc_cnt == 0) first_acc = cyc;
        acc_cnt++;
      end
      nv = 1'b0;
      nd = '0;
      if (spur) begin
        nv = 1'b1;
        nd = 32'hDEAD_BEEF;
      end else if (resp_on && rq.size() > 0) begin
        nv = 1'b1;
        nd = inst_of(rq.pop_front());
      end
      @(posedge clk);
      #1;
      resp_valid = nv;
      resp_data  = nd;
    end
  end

  // Monitor: every result consumed by decode must match the head of the queue.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && if_valid && !stall) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL if_result_unexpected: got pc=%h inst=%h, expected no result", if_pc, if_inst);
      end else begin
        e = expq.pop_front();
        pop_cyc.push_back(cyc);
        if (if_pc !== e.pc || if_inst !== e.inst) begin
          bad++;
          $display("FAIL if_result: got pc=%h inst=%h, expected pc=%h inst=%h",
                   if_pc, if_inst, e.pc, e.inst);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    expq.push_back(e);
  endtask

  // Keep fetching until n requests in total were accepted, then drop enable.
  task automatic wait_accepts(input int n);
    int t = 0;
    while (acc_cnt < n && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    enable = 1'b0;
    chk("accept_budget", 32'(acc_cnt), 32'(n));
  endtask

  task automatic drain();
    int t = 0;
    while ((expq.size() != 0 || rq.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    total++;
    if (t >= 200) begin
      bad++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", expq.size());
    end
    repeat (3) step();
  endtask

  initial begin
    int base;
    rst_n = 1'b0; enable = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = '0;
    req_ready = 1'b1; resp_valid = 1'b0; resp_data = '0;

    // Reset state, with enable already high.
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_addr",  req_addr, 32'h0);
    chk("rst_if_valid",  32'(if_valid), 32'd0);
    chk("rst_if_pc",     if_pc, 32'h0);
    chk("rst_if_inst",   if_inst, 32'h0);
    step();
    rst_n = 1'b1;

    // Streaming from reset: one result per cycle, accept-to-result latency 2.
    expect_res(32'h0, 32'h0000_0013);
    expect_res(32'h4, 32'h0000_0413);
    expect_res(32'h8, 32'h0000_0813);
    wait_accepts(3);
    drain();
    chk("latency",  32'(pop_cyc[0] - first_acc), 32'd2);
    chk("b2b_1",    32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    chk("b2b_2",    32'(pop_cyc[2] - pop_cyc[1]), 32'd1);

    // Stall with DEPTH=2: two accepts then the request is withheld.
    base = acc_cnt;
    stall = 1'b1; enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("full_req_valid", 32'(req_valid), 32'd0);
    chk("stall_hold_pc",  if_pc, 32'h0000_000C);
    step();
    chk("stall_accepts",  32'(acc_cnt - base), 32'd2);
    expect_res(32'h0C, 32'h0000_0C13);
    expect_res(32'h10, 32'h0000_1013);
    expect_res(32'h14, 32'h0000_1413);
    stall = 1'b0;
    wait_accepts(base + 3);
    drain();

    // Bus not ready: request and address hold even after enable drops.
    enable = 1'b1; req_ready = 1'b0;
    @(negedge clk);
    chk("hold_valid_0", 32'(req_valid), 32'd1);
    chk("hold_addr_0",  req_addr, 32'h18);
    step(); enable = 1'b0;
    @(negedge clk);
    chk("hold_valid_1", 32'(req_valid), 32'd1);
    chk("hold_addr_1",  req_addr, 32'h18);
    step();
    @(negedge clk);
    chk("hold_addr_2",  req_addr, 32'h18);
    expect_res(32'h18, 32'h0000_1813);
    step(); req_ready = 1'b1;
    drain();

    // Flush with two requests in flight: both late responses are dropped.
    base = acc_cnt;
    resp_on = 1'b0; enable = 1'b1;
    wait_accepts(base + 2);
    step(); flush = 1'b1; flush_pc = 32'h0000_0101;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("flush_if_valid", 32'(if_valid), 32'd0);
    chk("flush_next_pc",  req_addr, 32'h0000_0100);
    expect_res(32'h100, 32'h0001_0013);
    step(); resp_on = 1'b1; enable = 1'b1;
    wait_accepts(base + 3);
    drain();

    // Flush while stalled with a filled slot: output clears regardless.
    base = acc_cnt;
    resp_on = 1'b0; stall = 1'b1; enable = 1'b1;
    wait_accepts(base + 2);
    step(); resp_on = 1'b1;
    step(); resp_on = 1'b0;
    step(); step();
    @(negedge clk);
    chk("stalled_valid", 32'(if_valid), 32'd1);
    chk("stalled_pc",    if_pc, 32'h0000_0104);
    step(); flush = 1'b1; flush_pc = 32'h0000_0200;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("stall_flush_valid", 32'(if_valid), 32'd0);
    expect_res(32'h200, 32'h0002_0013);
    step(); stall = 1'b0; resp_on = 1'b1; enable = 1'b1;
    wait_accepts(base + 3);
    drain();

    // Flush while a request is pending-unaccepted: it stays, its data is dropped.
    base = acc_cnt;
    req_ready = 1'b0; enable = 1'b1;
    step(); flush = 1'b1; flush_pc = 32'h0000_0300;
    @(negedge clk);
    chk("stale_addr_f",  req_addr, 32'h0000_0204);
    step(); flush = 1'b0;
    @(negedge clk);
    chk("stale_valid_f1", 32'(req_valid), 32'd1);
    chk("stale_addr_f1",  req_addr, 32'h0000_0204);
    expect_res(32'h300, 32'h0003_0013);
    step(); req_ready = 1'b1;
    wait_accepts(base + 2);
    chk("after_stale_addr", acc_addrs[acc_addrs.size()-1], 32'h0000_0300);
    drain();

    // PC wrap at the top of the address space.
    base = acc_cnt;
    step(); flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step(); flush = 1'b0; enable = 1'b1;
    expect_res(32'hFFFF_FFFC, 32'hFFFF_FC13);
    expect_res(32'h0000_0000, 32'h0000_0013);
    wait_accepts(base + 2);
    chk("wrap_addr", acc_addrs[acc_addrs.size()-1], 32'h0);
    drain();

    // Response with nothing outstanding is ignored.
    base = acc_cnt;
    step(); spur = 1'b1;
    step(); spur = 1'b0;
    step();
    @(negedge clk);
    chk("spur_valid_0", 32'(if_valid), 32'd0);
    step();
    @(negedge clk);
    chk("spur_valid_1", 32'(if_valid), 32'd0);
    expect_res(32'h4, 32'h0000_0413);
    step(); enable = 1'b1;
    wait_accepts(base + 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
